rv_muldiv_unit: RTL

- Iterative multiply/divide coprocessor implementing the RV32M operations for the multicycle RV32I core, generalised to a parametrised datapath width.
- Sits beside the ALU in the DataPath. The ControlUnit issues one operation with a start pulse, stalls PC/register write-back while `busy` is high, and writes `result` on `done`.
- Processes one bit per cycle. Division by zero and signed overflow complete early.

---
 rtl/rv_muldiv_pkg.sv | 43 ++++
 rtl/rv_div_iter.sv | 31 +++
 rtl/rv_muldiv_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_muldiv_pkg.sv
// rv_muldiv_pkg: shared types and helpers for the iterative RV32M
// multiply/divide unit (rv_muldiv_unit and rv_div_iter).
package rv_muldiv_pkg;

  // Default operand/result width.
  localparam int XLEN_DEFAULT = 32;

  // Widest operand the magnitude helper accepts. Callers zero-extend their
  // operand into this width and truncate the answer back down. This is exact
  // because negation modulo 2^MAG_MAX_W, truncated, equals negation modulo
  // 2^XLEN.
  localparam int MAG_MAX_W = 128;

  // funct3 encodings of the eight RV32M operations.
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  // Control states. ST_DIV is only reachable when the divider is built.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  // Two's-complement magnitude: negate when the value is flagged negative.
  // The most-negative value maps onto itself, which read as unsigned is
  // exactly its magnitude, so no extra bit is required.
  function automatic logic [MAG_MAX_W-1:0] twos_mag(input logic [MAG_MAX_W-1:0] v,
                                                    input logic                 neg);
    return neg ? (~v + MAG_MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/rv_div_iter.sv
// rv_div_iter: one restoring-divide step. The partial remainder shifts left
// by one and takes in the next dividend bit. A trial subtraction of the
// divisor follows. If the subtraction does not borrow, its result becomes the
// new remainder and the quotient bit is 1. Otherwise the remainder is
// restored and the quotient bit is 0. Dividend bits and quotient bits share
// one register: the quotient bit enters at the LSB as the dividend shifts out
// at the MSB.
module rv_div_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          borrow;

  // The partial remainder is always smaller than the divisor. The shifted
  // value is therefore below 2*divisor and fits in XLEN+1 bits. The sign of
  // the difference is then a reliable borrow flag.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor_i};
  assign borrow  = diff[XLEN];
  assign rem_o   = borrow ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], ~borrow};

endmodule

// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M multiply/divide coprocessor, one bit per
// cycle. Operands are reduced to magnitudes at start. A shift-add multiply or
// a restoring divide runs for XLEN cycles. A FIX cycle then applies the sign
// rules and selects the result.
//
// Build option: define RV_MULDIV_DIV_EN to include the divider. Without it,
// DIV/DIVU/REM/REMU finish in one cycle with illegalOp=1 and result=0.
//
// Handshake: start is sampled only in IDLE, together with op/rs1/rs2. busy is
// high from the cycle after an accepted start through the done cycle,
// inclusive. done is a one-cycle pulse during which result is valid. result
// is then held until the next accepted start completes. start in any other
// state is ignored.
module rv_muldiv_unit
  import rv_muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegalOp,
  output logic [2:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);

  muldiv_state_e     state_q, state_d;
  muldiv_op_e        op_q, op_d;
  logic              s1_q, s1_d;         // rs1 treated as negative
  logic              s2_q, s2_d;         // rs2 treated as negative
  logic [XLEN-1:0]   a_q, a_d;           // |rs1|: multiplicand
  logic [XLEN-1:0]   b_q, b_d;           // |rs2|: divisor
  logic [2*XLEN-1:0] acc_q, acc_d;       // {high, low}: product, or {remainder, quotient}
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              illegal_q, illegal_d;

  // Decode of the incoming request.
  muldiv_op_e        op_in;
  logic              in_s1, in_s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              last_iter;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] prod;

  assign op_in     = muldiv_op_e'(op);
  assign in_s1     = rs1[XLEN-1] & (op_in inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  assign in_s2     = rs2[XLEN-1] & (op_in inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  assign mag1      = XLEN'(twos_mag(MAG_MAX_W'(rs1), in_s1));
  assign mag2      = XLEN'(twos_mag(MAG_MAX_W'(rs2), in_s2));
  assign last_iter = (cnt_q == CW'(XLEN - 1));

  // Shift-add step: add the multiplicand into the high half when the current
  // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? a_q : {XLEN{1'b0}})};
  assign prod    = (s1_q ^ s2_q) ? (~acc_q + (2*XLEN)'(1)) : acc_q;

`ifdef RV_MULDIV_DIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic            div_by_zero, div_ovf, early;
  logic [XLEN-1:0] early_res;
  logic [XLEN-1:0] div_rem, div_quo;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign div_by_zero = (rs2 == {XLEN{1'b0}});
  assign div_ovf     = (op_in inside {OP_DIV, OP_REM}) && (rs1 == MOST_NEG) && (rs2 == {XLEN{1'b1}});
  assign early       = op[2] & (div_by_zero | div_ovf);
  // op[1] selects remainder (REM/REMU) over quotient (DIV/DIVU).
  assign early_res   = div_by_zero ? (op[1] ? rs1 : {XLEN{1'b1}})
                                   : (op[1] ? {XLEN{1'b0}} : MOST_NEG);

  rv_div_iter #(.XLEN(XLEN)) u_div_iter (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .quo_i     (acc_q[XLEN-1:0]),
    .divisor_i (b_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  // The quotient is negated when the operand signs differ. The remainder
  // takes the sign of the dividend.
  assign quo_fix = XLEN'(twos_mag(MAG_MAX_W'(acc_q[XLEN-1:0]), s1_q ^ s2_q));
  assign rem_fix = XLEN'(twos_mag(MAG_MAX_W'(acc_q[2*XLEN-1:XLEN]), s1_q));
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!op[2]) begin
            state_d = ST_MUL;
          end else begin
`ifdef RV_MULDIV_DIV_EN
            state_d = early ? ST_DONE : ST_DIV;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_MUL:  if (last_iter) state_d = ST_FIX;
`ifdef RV_MULDIV_DIV_EN
      ST_DIV:  if (last_iter) state_d = ST_FIX;
`endif
      ST_FIX:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    illegalOp = (state_q == ST_DONE) & illegal_q;
    dbg_state = state_q;
    result    = result_q;
  end

  // Datapath next-state: operand capture, iteration, and sign fix-up.
  always_comb begin
    op_d      = op_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op_in;
          s1_d      = in_s1;
          s2_d      = in_s2;
          a_d       = mag1;
          b_d       = mag2;
          cnt_d     = '0;
          illegal_d = 1'b0;
          // Multiply: the multiplier sits in the low half. Divide: the
          // dividend sits in the low half and the remainder starts at zero.
          acc_d     = op[2] ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
`ifdef RV_MULDIV_DIV_EN
          if (early) result_d = early_res;
`else
          if (op[2]) begin
            illegal_d = 1'b1;
            result_d  = '0;
          end
`endif
        end
      end
      ST_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        cnt_d = cnt_q + CW'(1);
      end
`ifdef RV_MULDIV_DIV_EN
      ST_DIV: begin
        acc_d = {div_rem, div_quo};
        cnt_d = cnt_q + CW'(1);
      end
`endif
      ST_FIX: begin
        if (!op_q[2]) begin
          result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
`ifdef RV_MULDIV_DIV_EN
        else begin
          result_d = op_q[1] ? rem_fix : quo_fix;
        end
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers. An asynchronous reset clears everything, which also
  // aborts any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q      <= OP_MUL;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      op_q      <= op_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
